// File: rtl/q_table_arbiter.sv
// Shares the single-port Q-table RAM between the prediction and update requesters.
// Sweeps the table to zero after reset or on request.
module q_table_arbiter #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              pred_req,
  input  logic [IDX_W-1:0]  pred_idx,
  output logic              pred_ack,
  output logic              pred_jump,
  input  logic              upd_req,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_action,
  input  logic [DATA_W-1:0] upd_delta,
  output logic              upd_ack,
  output logic [IDX_W:0]    ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              clearing
);

  // state   | meaning
  // CLEAR   | zero sweep, one write per cycle
  // IDLE    | arbitrate clear / update / prediction
  // P_RD0   | read {idx,0}
  // P_RD1   | read {idx,1}, capture q0
  // P_CMP   | compare q1 against q0
  // U_RD    | read {idx,act}
  // U_WR    | write saturated sum
  localparam int AW = IDX_W + 1;
  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_P_RD0 = 3'd2;
  localparam logic [2:0] S_P_RD1 = 3'd3;
  localparam logic [2:0] S_P_CMP = 3'd4;
  localparam logic [2:0] S_U_RD  = 3'd5;
  localparam logic [2:0] S_U_WR  = 3'd6;

  logic [2:0]               state, state_nxt;
  logic [AW-1:0]            sweep_cnt;
  logic [IDX_W-1:0]         idx_q;
  logic                     act_q;
  logic [DATA_W-1:0]        delta_q;
  logic signed [DATA_W-1:0] q0;
  logic                     last_upd;
  logic                     grant_pred, grant_upd;
  logic [DATA_W:0]          sum;
  logic [DATA_W-1:0]        sat_sum;

  // After an update, a waiting prediction gets the next slot.
  always_comb begin
    grant_pred = 1'b0;
    grant_upd  = 1'b0;
    if (state == S_IDLE && !clear_req) begin
      grant_pred = pred_req && (last_upd || !upd_req);
      grant_upd  = upd_req && !grant_pred;
    end
  end

  always_comb begin
    sum     = {ram_rdata[DATA_W-1], ram_rdata} + {delta_q[DATA_W-1], delta_q};
    sat_sum = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1])
      sat_sum = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (sweep_cnt == {AW{1'b1}}) state_nxt = S_IDLE;
      S_IDLE: begin
        if (clear_req)       state_nxt = S_CLEAR;
        else if (grant_pred) state_nxt = S_P_RD0;
        else if (grant_upd)  state_nxt = S_U_RD;
      end
      S_P_RD0: state_nxt = S_P_RD1;
      S_P_RD1: state_nxt = S_P_CMP;
      S_P_CMP: state_nxt = S_IDLE;
      S_U_RD:  state_nxt = S_U_WR;
      S_U_WR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr = '0;
    case (state)
      S_CLEAR:        ram_addr = sweep_cnt;
      S_P_RD0:        ram_addr = {idx_q, 1'b0};
      S_P_RD1:        ram_addr = {idx_q, 1'b1};
      S_P_CMP:        ram_addr = {idx_q, 1'b1};
      S_U_RD, S_U_WR: ram_addr = {idx_q, act_q};
      default:        ram_addr = '0;
    endcase
  end

  // Writes are gated by rst_n so nothing reaches the RAM while reset is held.
  assign ram_we    = rst_n && (state == S_CLEAR || state == S_U_WR);
  assign ram_wdata = (rst_n && state == S_U_WR) ? sat_sum : '0;
  assign busy      = (state != S_IDLE);
  assign clearing  = (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      sweep_cnt <= '0;
      pred_ack  <= 1'b0;
      pred_jump <= 1'b0;
      upd_ack   <= 1'b0;
      last_upd  <= 1'b0;
      idx_q     <= '0;
      act_q     <= 1'b0;
      delta_q   <= '0;
      q0        <= '0;
    end else begin
      state    <= state_nxt;
      pred_ack <= 1'b0;
      upd_ack  <= 1'b0;
      if (state == S_CLEAR) sweep_cnt <= sweep_cnt + AW'(1);
      if (grant_pred) begin
        idx_q    <= pred_idx;
        last_upd <= 1'b0;
      end
      if (grant_upd) begin
        idx_q    <= upd_idx;
        act_q    <= upd_action;
        delta_q  <= upd_delta;
        last_upd <= 1'b1;
      end
      if (state == S_P_RD1) q0 <= $signed(ram_rdata);
      if (state == S_P_CMP) begin
        pred_ack  <= 1'b1;
        pred_jump <= ($signed(ram_rdata) > q0);
      end
      if (state == S_U_WR) upd_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_q_table_arbiter.sv
// Bench for q_table_arbiter: synchronous RAM model plus an array-based Q-table reference.
module tb_q_table_arbiter;
  localparam int IDX_W  = 2;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear_req = 1'b0;
  logic              pred_req = 1'b0;
  logic [IDX_W-1:0]  pred_idx = '0;
  logic              pred_ack, pred_jump;
  logic              upd_req = 1'b0;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic              upd_action = 1'b0;
  logic [DATA_W-1:0] upd_delta = '0;
  logic              upd_ack;
  logic [IDX_W:0]    ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy, clearing;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              pl_en = 1'b0;
  logic [IDX_W:0]    pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  int model [DEPTH];
  int n_checks = 0;
  int n_fail = 0;
  bit last_was_upd = 1'b0;

  q_table_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .pred_req(pred_req), .pred_idx(pred_idx), .pred_ack(pred_ack), .pred_jump(pred_jump),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_action(upd_action), .upd_delta(upd_delta),
    .upd_ack(upd_ack), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .clearing(clearing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic poke(input int a, input int v);
    pl_en = 1'b1; pl_addr = a[IDX_W:0]; pl_data = v[DATA_W-1:0];
    @(negedge clk);
    pl_en = 1'b0;
    model[a] = v;
  endtask

  task automatic run_pred(input int idx, output int lat, output logic jump);
    pred_idx = idx[IDX_W-1:0]; pred_req = 1'b1; lat = -1; jump = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (pred_ack) begin lat = n; jump = pred_jump; break; end
    end
    pred_req = 1'b0;
    last_was_upd = 1'b0;
  endtask

  task automatic run_upd(input int idx, input int act, input int delta,
                         output int lat, output int wcount, output int wval);
    upd_idx = idx[IDX_W-1:0]; upd_action = act[0]; upd_delta = delta[DATA_W-1:0];
    upd_req = 1'b1; lat = -1; wcount = 0; wval = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ram_we) begin wcount++; wval = int'($signed(ram_wdata)); end
      if (upd_ack) begin lat = n; break; end
    end
    upd_req = 1'b0;
    last_was_upd = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pred_ack, pred_jump, upd_ack, ram_we, ram_wdata, ram_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b jump=%b uack=%b we=%b wdata=%h addr=%h, required all 0",
               pred_ack, pred_jump, upd_ack, ram_we, ram_wdata, ram_addr);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (!(ram_we === 1'b1 && ram_addr === i[IDX_W:0] && ram_wdata === '0 && busy === 1'b1
            && clearing === 1'b1 && pred_ack === 1'b0 && upd_ack === 1'b0)) begin
        n_fail++;
        $display("FAIL reset_sweep[%0d]: we=%b addr=%0d wdata=%h busy=%b clr=%b, required we=1 addr=%0d wdata=0 busy=1 clr=1",
                 i, ram_we, ram_addr, ram_wdata, busy, clearing, i);
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || clearing !== 1'b0 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sweep_end: busy=%b clearing=%b we=%b, required 0 0 0", busy, clearing, ram_we);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
  endtask

  task automatic test_pred_basic(input int q0, input int q1, input string nm);
    int lat; logic jump; logic exp;
    poke(4, q0);
    poke(5, q1);
    exp = (model[5] > model[4]);
    run_pred(2, lat, jump);
    n_checks++;
    if (lat !== 4 || jump !== exp) begin
      n_fail++;
      $display("FAIL %s: latency=%0d jump=%b, required latency=4 jump=%b", nm, lat, jump, exp);
    end
  endtask

  task automatic test_saturation();
    int cases [3][3] = '{'{120, 20, 127}, '{-120, -20, -128}, '{10, -3, 7}};
    int lat, wc, wv;
    for (int k = 0; k < 3; k++) begin
      poke(3, cases[k][0]);
      run_upd(1, 1, cases[k][1], lat, wc, wv);
      model[3] = sat(cases[k][0] + cases[k][1]);
      n_checks++;
      if (lat !== 3 || wc !== 1 || wv !== cases[k][2] || int'($signed(mem[3])) !== model[3]) begin
        n_fail++;
        $display("FAIL sat_%0d: latency=%0d writes=%0d wdata=%0d, required latency=3 writes=1 wdata=%0d",
                 k, lat, wc, wv, cases[k][2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, ua, pa; logic j, pj, exp;
    run_pred(0, lat, j);
    poke(2, 0);
    poke(3, 2);
    upd_idx = 2'd1; upd_action = 1'b0; upd_delta = 8'd4;
    pred_idx = 2'd1;
    upd_req = 1'b1; pred_req = 1'b1;
    ua = -1; pa = -1; pj = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (upd_ack) begin ua = n; upd_req = 1'b0; end
      if (pred_ack) begin pa = n; pj = pred_jump; pred_req = 1'b0; break; end
    end
    upd_req = 1'b0; pred_req = 1'b0;
    last_was_upd = 1'b0;
    model[2] = sat(model[2] + 4);
    exp = (model[3] > model[2]);
    n_checks++;
    if (ua !== 3 || pa !== 7 || pj !== exp) begin
      n_fail++;
      $display("FAIL back_to_back: upd_ack@%0d pred_ack@%0d jump=%b, required 3 7 %b", ua, pa, pj, exp);
    end
  endtask

  task automatic test_fairness();
    bit expect_upd; int prev, seen; int delta;
    delta = int'($urandom_range(0, 40)) - 20;
    poke(0, int'($urandom_range(0, 60)) - 30);
    poke(1, int'($urandom_range(0, 60)) - 30);
    upd_idx = 2'd0; upd_action = 1'b1; upd_delta = delta[DATA_W-1:0];
    pred_idx = 2'd0;
    expect_upd = !last_was_upd;
    upd_req = 1'b1; pred_req = 1'b1;
    prev = 0; seen = 0;
    for (int n = 1; n <= 60 && seen < 8; n++) begin
      @(negedge clk);
      if (upd_ack || pred_ack) begin
        seen++;
        if (seen == 8) begin upd_req = 1'b0; pred_req = 1'b0; end
        n_checks++;
        if (upd_ack) begin
          model[1] = sat(model[1] + delta);
          if (!expect_upd || pred_ack || n - prev !== 3) begin
            n_fail++;
            $display("FAIL fairness[%0d]: got upd after %0d cycles, required %s after %0d",
                     seen, n - prev, expect_upd ? "upd" : "pred", expect_upd ? 3 : 4);
          end
        end else begin
          if (expect_upd || n - prev !== 4 || pred_jump !== (model[1] > model[0])) begin
            n_fail++;
            $display("FAIL fairness[%0d]: got pred after %0d cycles jump=%b, required %s after %0d jump=%b",
                     seen, n - prev, pred_jump, expect_upd ? "upd" : "pred", expect_upd ? 3 : 4,
                     (model[1] > model[0]));
          end
        end
        last_was_upd = upd_ack;
        expect_upd = !upd_ack;
        prev = n;
      end
    end
    upd_req = 1'b0; pred_req = 1'b0;
    n_checks++;
    if (seen !== 8) begin
      n_fail++;
      $display("FAIL fairness_count: acks=%0d, required 8", seen);
    end
  endtask

  task automatic test_random();
    int lat, wc, wv, idx, act, delta, a, exp;
    logic j, ej;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 4)
        poke(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)) - 128);
      idx = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        act = int'($urandom_range(0, 1));
        delta = int'($urandom_range(0, 255)) - 128;
        a = idx * 2 + act;
        exp = sat(model[a] + delta);
        run_upd(idx, act, delta, lat, wc, wv);
        model[a] = exp;
        n_checks++;
        if (lat !== 3 || wc !== 1 || wv !== exp) begin
          n_fail++;
          $display("FAIL rand_upd[%0d]: latency=%0d writes=%0d wdata=%0d, required 3 1 %0d", k, lat, wc, wv, exp);
        end
      end else begin
        ej = (model[idx * 2 + 1] > model[idx * 2]);
        run_pred(idx, lat, j);
        n_checks++;
        if (lat !== 4 || j !== ej) begin
          n_fail++;
          $display("FAIL rand_pred[%0d]: latency=%0d jump=%b, required 4 %b", k, lat, j, ej);
        end
      end
    end
  endtask

  task automatic test_clear_mid();
    int ua, wc, cnt, bad;
    poke(6, 50);
    upd_idx = 2'd3; upd_action = 1'b0; upd_delta = 8'd5;
    upd_req = 1'b1; ua = -1; wc = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) clear_req = 1'b1;
      if (ram_we && !clearing) wc++;
      if (upd_ack) begin ua = n; upd_req = 1'b0; break; end
    end
    upd_req = 1'b0;
    last_was_upd = 1'b1;
    n_checks++;
    if (ua !== 3 || wc !== 1 || mem[6] !== 8'd55) begin
      n_fail++;
      $display("FAIL clear_mid_upd: upd_ack@%0d writes=%0d mem=%0d, required 3 1 55", ua, wc, mem[6]);
    end
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!clearing) break;
      if (ram_we && ram_wdata === '0) cnt++;
      @(negedge clk);
    end
    clear_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (int'($signed(mem[i])) !== model[i]) bad++;
    n_checks++;
    if (cnt !== 8 || bad !== 0) begin
      n_fail++;
      $display("FAIL clear_mid_sweep: zero writes=%0d nonzero entries=%0d, required 8 0", cnt, bad);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_no_resweep: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int bad; bit ack_seen;
    poke(5, 77);
    upd_idx = 2'd2; upd_action = 1'b1; upd_delta = 8'd1;
    upd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b0 || upd_ack !== 1'b0 || mem[5] !== 8'd77) begin
      n_fail++;
      $display("FAIL reset_mid_abandon: we=%b upd_ack=%b mem=%0d, required 0 0 77", ram_we, upd_ack, mem[5]);
    end
    rst_n = 1'b1; upd_req = 1'b0;
    #1;
    ack_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (upd_ack) ack_seen = 1'b1;
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== i[IDX_W:0] || ram_wdata !== '0) begin
        n_fail++;
        $display("FAIL reset_mid_sweep[%0d]: we=%b addr=%0d, required we=1 addr=%0d", i, ram_we, ram_addr, i);
      end
      @(negedge clk);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (int'($signed(mem[i])) !== model[i]) bad++;
    n_checks++;
    if (busy !== 1'b0 || ack_seen || upd_ack !== 1'b0 || bad !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_end: busy=%b ack_seen=%b nonzero=%0d, required 0 0 0", busy, ack_seen, bad);
    end
  endtask

  initial begin
    test_reset();
    test_pred_basic(3, 5, "pred_jump");
    test_pred_basic(5, 5, "pred_tie");
    test_pred_basic(-2, -7, "pred_neg");
    test_saturation();
    test_back_to_back();
    test_fairness();
    test_random();
    test_clear_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
